asynchronous_fifo: RTL and testbench



---
 rtl/asynchronous_fifo.sv | 88 ++++++++
 tb/tb_asynchronous_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo.sv
// First-word-fall-through FIFO using Gray-coded pointers with two-flop pointer
// synchronisers, currently clocked from a single clock ahead of a dual-clock split.
module asynchronous_fifo #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 3
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_WIDTH:0] wbin, wgray, rbin, rgray;
   logic [PTR_WIDTH:0] wbin_next, rbin_next, wgray_next, rgray_next;
   logic [PTR_WIDTH:0] wgray_rd_p0, wgray_rd_p1;
   logic [PTR_WIDTH:0] rgray_wr_p0, rgray_wr_p1;
   logic [PTR_WIDTH:0] full_match;
   logic               w_acc, r_acc;

   assign w_acc      = w_en && !full;
   assign r_acc      = r_en && !empty;
   assign wbin_next  = wbin + {{PTR_WIDTH{1'b0}}, w_acc};
   assign rbin_next  = rbin + {{PTR_WIDTH{1'b0}}, r_acc};
   assign wgray_next = bin2gray(wbin_next);
   assign rgray_next = bin2gray(rbin_next);

   // Full when the write pointer has lapped the read pointer: the two MSBs
   // differ and the rest match in Gray code.
   assign full_match = {~rgray_wr_p1[PTR_WIDTH:PTR_WIDTH-1], rgray_wr_p1[PTR_WIDTH-2:0]};

   assign data_out = mem[rbin[PTR_WIDTH-1:0]];

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (w_acc) begin
         mem[wbin[PTR_WIDTH-1:0]] <= data_in;
      end
   end

   // Write side: pointers, read-pointer synchroniser, full flag
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wbin        <= '0;
         wgray       <= '0;
         rgray_wr_p0 <= '0;
         rgray_wr_p1 <= '0;
         full        <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wgray       <= wgray_next;
         rgray_wr_p0 <= rgray;
         rgray_wr_p1 <= rgray_wr_p0;
         full        <= (wgray_next == full_match);
      end
   end

   // Read side: pointers, write-pointer synchroniser, empty flag
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         rbin        <= '0;
         rgray       <= '0;
         wgray_rd_p0 <= '0;
         wgray_rd_p1 <= '0;
         empty       <= 1'b1;
      end else begin
         rbin        <= rbin_next;
         rgray       <= rgray_next;
         wgray_rd_p0 <= wgray;
         wgray_rd_p1 <= wgray_rd_p0;
         empty       <= (rgray_next == wgray_rd_p1);
      end
   end

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Bench for asynchronous_fifo: directed table, corner-case sequences and a
// randomized run against a count/queue reference model.
module tb_asynchronous_fifo;

   localparam int DEPTH      = 8;
   localparam int DATA_WIDTH = 8;
   localparam int PTR_WIDTH  = 3;

   logic                  wclk = 1'b0;
   logic                  wrst_n = 1'b0;
   logic                  w_en = 1'b0;
   logic                  r_en = 1'b0;
   logic [DATA_WIDTH-1:0] data_in = '0;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;

   asynchronous_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .PTR_WIDTH(PTR_WIDTH)
   ) dut (
      .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .r_en(r_en),
      .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
   );

   always #5 wclk = ~wclk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: stored words as a queue, total write/read counts, and
   // the counts as they were 1..3 edges ago (what the opposite side sees).
   logic [7:0] q[$];
   int  wcnt, rcnt;
   int  wh[3];
   int  rh[3];
   bit  m_empty = 1'b1;
   bit  m_full  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rst_n_i, input logic we, input logic re,
                             input logic [7:0] din);
      bit wa, ra;
      if (!rst_n_i) begin
         q.delete();
         wcnt = 0; rcnt = 0;
         for (int i = 0; i < 3; i++) begin wh[i] = 0; rh[i] = 0; end
         m_empty = 1'b1;
         m_full  = 1'b0;
      end else begin
         wa = we && !m_full;
         ra = re && !m_empty;
         if (ra) void'(q.pop_front());
         if (wa) q.push_back(din);
         wcnt += int'(wa);
         rcnt += int'(ra);
         m_empty = (rcnt == wh[2]);
         m_full  = ((wcnt - rh[2]) == DEPTH);
         wh[2] = wh[1]; wh[1] = wh[0]; wh[0] = wcnt;
         rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = rcnt;
      end
   endtask

   task automatic step(input logic rst_n_i, input logic we, input logic re,
                       input logic [7:0] din);
      @(negedge wclk);
      wrst_n = rst_n_i; w_en = we; r_en = re; data_in = din;
      @(posedge wclk);
      model_edge(rst_n_i, we, re, din);
      #1;
      chk("empty", empty, m_empty);
      chk("full", full, m_full);
      if (!rst_n_i) chk("dout_rst", data_out, 0);
      else if (!m_empty) chk("head", data_out, q[0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   // Checks the head word before the read edge, then performs the read.
   task automatic read_chk(input logic [7:0] exp, input string name);
      chk(name, data_out, exp);
      step(1'b1, 1'b0, 1'b1, 8'h00);
   endtask

   typedef struct {
      logic       rst_n;
      logic       we;
      logic       re;
      logic [7:0] din;
      logic       e_empty;
      logic       e_full;
      logic [7:0] e_dout;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 8'hA1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].rst_n, tbl[i].we, tbl[i].re, tbl[i].din);
         chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
         chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
         chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].e_dout);
      end

      // Sequential writes and reads with long gaps
      step(1'b1, 1'b1, 1'b0, 8'h24); idle(10);
      step(1'b1, 1'b1, 1'b0, 8'h81); idle(10);
      step(1'b1, 1'b1, 1'b0, 8'h09); idle(10);
      read_chk(8'h24, "seq0"); idle(10);
      read_chk(8'h81, "seq1"); idle(10);
      read_chk(8'h09, "seq2");
      chk("seq_empty", empty, 1);
      idle(4);

      // Fill, dropped overflow write, drain; then two wrap passes
      for (int pass = 0; pass < 3; pass++) begin
         for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 8'(pass * 16 + i));
         chk("fill_full", full, 1);
         step(1'b1, 1'b1, 1'b0, 8'hFF);
         idle(3);
         for (int i = 0; i < DEPTH; i++) read_chk(8'(pass * 16 + i), $sformatf("drain%0d", pass));
         chk("drain_empty", empty, 1);
         chk("drain_full", full, 0);
         idle(4);
      end

      // Reads held while empty, then a single word
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h5A); idle(3);
      read_chk(8'h5A, "underflow_5a");
      idle(4);

      // Simultaneous read/write at occupancy 4
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
      idle(4);
      for (int i = 0; i < 4; i++) begin
         chk("simul_head", data_out, 8'(8'h40 + i));
         step(1'b1, 1'b1, 1'b1, 8'(8'h44 + i));
         chk("simul_nonempty", empty, 0);
      end
      idle(4);
      for (int i = 0; i < 4; i++) read_chk(8'(8'h44 + i), "simul_drain");
      chk("simul_empty", empty, 1);

      // Mid-operation reset with 5 entries stored
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
      idle(4);
      step(1'b0, 1'b1, 1'b1, 8'hEE);
      chk("midrst_empty", empty, 1);
      chk("midrst_full", full, 0);
      chk("midrst_dout", data_out, 0);
      step(1'b1, 1'b1, 1'b0, 8'h33); idle(3);
      read_chk(8'h33, "midrst_33");
      idle(4);

      // Randomized traffic with varying write/read bias and rare resets
      for (int blk = 0; blk < 8; blk++) begin
         int wb, rb;
         wb = $urandom_range(10, 90);
         rb = $urandom_range(10, 90);
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 99) < wb,
                 $urandom_range(0, 99) < rb,
                 8'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
